// File: rtl/serial_add_arb.sv
// Bit-serial adder shared by two requesters: round-robin grant, LSB-first
// shifting through one full-adder cell, registered sum/carry with a done pulse.
module serial_add_arb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             owner
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             cur_q, cur_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d;
    logic             owner_q, owner_d;

    logic             win;
    logic             fa_sum;
    logic             fa_cout;

    assign fa_sum  = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign fa_cout = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ps_d    = ps_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cur_d   = cur_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done_d  = 1'b0;
        y_d     = y_q;
        cout_d  = cout_q;
        owner_d = owner_q;
        win     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    // On a tie the requester not served last wins.
                    win     = (req0 & req1) ? ~last_q : req1;
                    sa_d    = win ? a1 : a0;
                    sb_d    = win ? b1 : b0;
                    carry_d = win ? cin1 : cin0;
                    ps_d    = '0;
                    cur_d   = win;
                    last_d  = win;
                    cnt_d   = '0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                ps_d    = {fa_sum, ps_q[WIDTH-1:1]};
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    y_d     = {fa_sum, ps_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    owner_d = cur_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            ps_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            cur_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ps_q    <= ps_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done_q  <= done_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            owner_q <= owner_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign y     = y_q;
    assign cout  = cout_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_serial_add_arb.sv
// Directed self-checking bench for serial_add_arb with WIDTH=4.
module tb_serial_add_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       cin0 = 1'b0, cin1 = 1'b0;
    logic       gnt0, gnt1, busy, done, cout, owner;
    logic [3:0] y;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    serial_add_arb #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .y(y), .cout(cout), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance one edge and settle past it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fail(input string name, input int got, input int exp);
        errors++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Request one operation from requester 'who' and follow it to completion.
    task automatic do_op(input string name, input logic who, input logic [3:0] a, input logic [3:0] b,
                         input logic ci, input logic [3:0] ey, input logic ec);
        bit got = 0;
        if (who) begin a1 = a; b1 = b; cin1 = ci; req1 = 1'b1; end
        else     begin a0 = a; b0 = b; cin0 = ci; req0 = 1'b1; end
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (gnt0 | gnt1) got = 1;
        end
        checks++; if (!got) fail({name, "_grant_timeout"}, 0, 1);
        checks++; if ({gnt1, gnt0} !== (who ? 2'b10 : 2'b01)) fail({name, "_gnt"}, {gnt1, gnt0}, who ? 2 : 1);
        checks++; if (busy !== 1'b1) fail({name, "_busy"}, busy, 1);
        if (who) req1 = 1'b0; else req0 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (done !== 1'b0) fail({name, "_early_done"}, done, 0);
        end
        step();
        checks++; if (done !== 1'b1) fail({name, "_done"}, done, 1);
        checks++; if (y !== ey) fail({name, "_y"}, y, ey);
        checks++; if (cout !== ec) fail({name, "_cout"}, cout, ec);
        checks++; if (owner !== who) fail({name, "_owner"}, owner, who);
        step();
        checks++; if (done !== 1'b0) fail({name, "_done_pulse"}, done, 0);
        checks++; if (busy !== 1'b0) fail({name, "_idle"}, busy, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
        step(); step();
        checks++; if (gnt0 !== 1'b0)  fail("rst_gnt0", gnt0, 0);
        checks++; if (gnt1 !== 1'b0)  fail("rst_gnt1", gnt1, 0);
        checks++; if (busy !== 1'b0)  fail("rst_busy", busy, 0);
        checks++; if (done !== 1'b0)  fail("rst_done", done, 0);
        checks++; if (y !== 4'h0)     fail("rst_y", y, 0);
        checks++; if (cout !== 1'b0)  fail("rst_cout", cout, 0);
        checks++; if (owner !== 1'b0) fail("rst_owner", owner, 0);
        rst = 1'b0;
        step();
        checks++; if ({gnt1, gnt0} !== 2'b01) fail("rst_first_grant", {gnt1, gnt0}, 1);
        req0 = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_single_add();
        do_op("single", 1'b0, 4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0);
    endtask

    task automatic test_carry();
        do_op("carry_f1", 1'b1, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
        do_op("carry_ff", 1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
    endtask

    task automatic test_round_robin();
        int ng = 0;
        int last_cyc = 0;
        logic last_who = 1'b0;
        a0 = 4'h1; b0 = 4'h2; cin0 = 1'b0;
        a1 = 4'h7; b1 = 4'h7; cin1 = 1'b1;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int n = 0; n < 30; n++) begin
            step();
            checks++; if ((gnt0 & gnt1) | ((gnt0 | gnt1) & done)) fail("rr_exclusive", {done, gnt1, gnt0}, 0);
            if (gnt0 | gnt1) begin
                checks++; if (gnt1 !== ng[0]) fail("rr_order", {gnt1, gnt0}, ng[0] ? 2 : 1);
                if (ng > 0) begin
                    checks++; if (cyc - last_cyc != 6) fail("rr_spacing", cyc - last_cyc, 6);
                end
                last_cyc = cyc;
                last_who = gnt1;
                ng++;
            end
            if (done) begin
                checks++; if (owner !== last_who) fail("rr_owner", owner, last_who);
                checks++; if (y !== (last_who ? 4'hF : 4'h3)) fail("rr_y", y, last_who ? 15 : 3);
                checks++; if (cout !== 1'b0) fail("rr_cout", cout, 0);
            end
        end
        checks++; if (ng < 4) fail("rr_grant_count", ng, 4);
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_abort();
        bit got = 0;
        bit seen_done = 0;
        a0 = 4'h9; b0 = 4'h9; cin0 = 1'b0; req0 = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (gnt0) got = 1;
        end
        checks++; if (!got) fail("abort_grant_timeout", 0, 1);
        req0 = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) fail("abort_busy", busy, 0);
        checks++; if (y !== 4'h0)    fail("abort_y", y, 0);
        checks++; if (cout !== 1'b0) fail("abort_cout", cout, 0);
        for (int n = 0; n < 8; n++) begin
            step();
            if (done) seen_done = 1;
        end
        checks++; if (seen_done) fail("abort_no_done", 1, 0);
        do_op("after_abort", 1'b0, 4'h6, 4'h7, 1'b1, 4'hE, 1'b0);
    endtask

    task automatic test_late_request();
        bit got = 0;
        a0 = 4'h2; b0 = 4'h3; cin0 = 1'b0; req0 = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (gnt0) got = 1;
        end
        checks++; if (!got) fail("late_grant0_timeout", 0, 1);
        req0 = 1'b0;
        a1 = 4'hA; b1 = 4'hA; cin1 = 1'b0; req1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++; if (gnt1 !== 1'b0) fail("late_no_gnt1", gnt1, 0);
            if (k == 4) begin
                checks++; if (y !== 4'h5 || done !== 1'b1) fail("late_first_result", {done, y}, 5'h15);
            end
        end
        a1 = 4'h3; b1 = 4'h4; cin1 = 1'b1;
        step();
        checks++; if (gnt1 !== 1'b1) fail("late_gnt1_at_6", gnt1, 1);
        req1 = 1'b0; a1 = 4'hF; b1 = 4'hF; cin1 = 1'b0;
        repeat (4) step();
        checks++; if (done !== 1'b1) fail("late_done", done, 1);
        checks++; if (y !== 4'h8)    fail("late_y", y, 8);
        checks++; if (cout !== 1'b0) fail("late_cout", cout, 0);
        checks++; if (owner !== 1'b1) fail("late_owner", owner, 1);
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_carry();
        test_round_robin();
        test_abort();
        test_late_request();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
